branch_sequencer: RTL and testbench

Multi-cycle program-counter sequencer for KGP-RISC. Owns the PC and flag register, drives the instruction-fetch handshake, and resolves every control-transfer instruction (conditional, unconditional, register, branch-and-link) into the next PC. Sits between instruction memory, the decoder/ALU datapath and the register file link port, replacing the free-running PC plus combinational next-PC logic.

---
 rtl/branch_sequencer_if.sv | 25 ++
 rtl/branch_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_branch_sequencer.sv | 613 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_sequencer_if.sv
// Fetch and decode/execute handshake bundle between the PC
// sequencer (master) and the fetch unit / datapath (slave).
interface branch_sequencer_if;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ack;
  logic        dec_valid;
  logic        exec_done;

  modport master (
    output fetch_req,
    output fetch_addr,
    input  fetch_ack,
    output dec_valid,
    input  exec_done
  );

  modport slave (
    input  fetch_req,
    input  fetch_addr,
    output fetch_ack,
    input  dec_valid,
    output exec_done
  );
endinterface

// File: rtl/branch_sequencer.sv
// KGP-RISC multi-cycle PC sequencer: fetch handshake, flags, next-PC.
// Optional taken-branch counter built only when BRANCH_STATS_EN is defined.
module branch_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  branch_sequencer_if.master bus,
  input  logic        flags_we,
  input  logic        zero_in,
  input  logic        carry_in,
  input  logic        negative_in,
  input  logic        cond_br,
  input  logic        uncond_br,
  input  logic        reg_br,
  input  logic        halt_in,
  input  logic [1:0]  cond_ctrl,
  input  logic [1:0]  uncond_ctrl,
  input  logic [31:0] immediate,
  input  logic [25:0] pseudo_add,
  input  logic [31:0] register,
  output logic [31:0] pc,
  output logic        link_we,
  output logic [31:0] link_addr,
  output logic        taken,
  output logic        halted,
  output logic        fault,
  output logic [15:0] taken_count
);

  localparam int TW = (FETCH_TIMEOUT > 2) ?
                      $clog2(FETCH_TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(FETCH_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_t;

  state_t state;
  state_t state_next;

  logic [TW-1:0] timer;
  logic          exec_first;
  logic          flag_z;
  logic          flag_c;
  logic          flag_n;
  logic [31:0]   pc_plus4;
  logic [31:0]   pc_next;
  logic          take;
  logic          link;
  logic          cond_true;
  logic          retire;

  assign pc_plus4 = pc + 32'd4;
  assign retire   = (state == S_EXEC) && bus.exec_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (start) state_next = S_FETCH;
      end
      S_FETCH: begin
        if (bus.fetch_ack)
          state_next = S_EXEC;
        else if (timer == T_LAST)
          state_next = S_HALT;
      end
      S_EXEC: begin
        if (bus.exec_done)
          state_next = halt_in ? S_HALT : S_FETCH;
      end
      S_HALT: state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.fetch_req  = (state == S_FETCH);
    bus.fetch_addr = pc;
    bus.dec_valid  = (state == S_EXEC) && exec_first;
    halted         = (state == S_HALT);
  end

  // Timer only runs while waiting in FETCH, so every entry starts at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer <= '0;
    end else if (state != S_FETCH) begin
      timer <= '0;
    end else if (!bus.fetch_ack && timer != T_LAST) begin
      timer <= timer + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) exec_first <= 1'b0;
    else      exec_first <= (state == S_FETCH) && bus.fetch_ack;
  end

  always_comb begin
    cond_true = 1'b0;
    unique case (cond_ctrl)
      2'b00: cond_true = flag_n;
      2'b01: cond_true = flag_z;
      2'b10: cond_true = !flag_z;
      2'b11: cond_true = flag_c;
      default: cond_true = 1'b0;
    endcase
  end

  // Fixed priority: halt > reg > uncond > cond > sequential.
  always_comb begin
    pc_next = pc_plus4;
    take    = 1'b0;
    link    = 1'b0;
    if (halt_in) begin
      pc_next = pc;
    end else if (reg_br) begin
      pc_next = {register[31:2], 2'b00};
      take    = 1'b1;
    end else if (uncond_br) begin
      if (uncond_ctrl[1] == 1'b0) begin
        pc_next = {pc_plus4[31:28], pseudo_add, 2'b00};
        take    = 1'b1;
        link    = uncond_ctrl[0];
      end
    end else if (cond_br && cond_true) begin
      pc_next = pc_plus4 + immediate;
      take    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= RESET_PC;
      link_we   <= 1'b0;
      link_addr <= '0;
      taken     <= 1'b0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_n    <= 1'b0;
    end else begin
      link_we <= 1'b0;
      taken   <= 1'b0;
      if (retire) begin
        pc      <= pc_next;
        link_we <= link;
        taken   <= take;
        if (link) link_addr <= pc_plus4;
        // Condition above already used the pre-update flags.
        if (flags_we) begin
          flag_z <= zero_in;
          flag_c <= carry_in;
          flag_n <= negative_in;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault <= 1'b0;
    end else if (state == S_FETCH && state_next == S_HALT) begin
      fault <= 1'b1;
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      taken_count <= '0;
    end else if (retire && take && taken_count != 16'hFFFF) begin
      taken_count <= taken_count + 16'd1;
    end
  end
`else
  assign taken_count = 16'h0000;
`endif

  logic unused_bits;
  assign unused_bits = ^register[1:0];

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed self-checking bench for branch_sequencer.
// Expected PCs, links and counts are hand-computed constants.
module tb_branch_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        flags_we;
  logic        zero_in;
  logic        carry_in;
  logic        negative_in;
  logic        cond_br;
  logic        uncond_br;
  logic        reg_br;
  logic        halt_in;
  logic [1:0]  cond_ctrl;
  logic [1:0]  uncond_ctrl;
  logic [31:0] immediate;
  logic [25:0] pseudo_add;
  logic [31:0] register;
  logic [31:0] pc;
  logic        link_we;
  logic [31:0] link_addr;
  logic        taken;
  logic        halted;
  logic        fault;
  logic [15:0] taken_count;

  int vectors;
  int miscompares;
  int exp_cnt;

  branch_sequencer_if bus ();

  branch_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bus         (bus.master),
    .flags_we    (flags_we),
    .zero_in     (zero_in),
    .carry_in    (carry_in),
    .negative_in (negative_in),
    .cond_br     (cond_br),
    .uncond_br   (uncond_br),
    .reg_br      (reg_br),
    .halt_in     (halt_in),
    .cond_ctrl   (cond_ctrl),
    .uncond_ctrl (uncond_ctrl),
    .immediate   (immediate),
    .pseudo_add  (pseudo_add),
    .register    (register),
    .pc          (pc),
    .link_we     (link_we),
    .link_addr   (link_addr),
    .taken       (taken),
    .halted      (halted),
    .fault       (fault),
    .taken_count (taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ins();
    flags_we    = 0;
    zero_in     = 0;
    carry_in    = 0;
    negative_in = 0;
    cond_br     = 0;
    uncond_br   = 0;
    reg_br      = 0;
    halt_in     = 0;
    cond_ctrl   = 0;
    uncond_ctrl = 0;
    immediate   = 0;
    pseudo_add  = 0;
    register    = 0;
  endtask

  task automatic wait_fetch();
    int n;
    n = 0;
    while (!bus.fetch_req && n < 20) begin
      tick();
      n++;
    end
    vectors++;
    if (bus.fetch_req !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_fetch: fetch_req=%b want 1",
               bus.fetch_req);
    end
  endtask

  task automatic exec_instr(
    input logic        cb,
    input logic        ub,
    input logic        rb,
    input logic        hi,
    input logic [1:0]  cc,
    input logic [1:0]  uc,
    input logic [31:0] imm,
    input logic [25:0] pa,
    input logic [31:0] rg,
    input logic        fwe,
    input logic        z,
    input logic        c,
    input logic        n
  );
    wait_fetch();
    bus.fetch_ack = 1;
    tick();
    bus.fetch_ack = 0;
    cond_br       = cb;
    uncond_br     = ub;
    reg_br        = rb;
    halt_in       = hi;
    cond_ctrl     = cc;
    uncond_ctrl   = uc;
    immediate     = imm;
    pseudo_add    = pa;
    register      = rg;
    flags_we      = fwe;
    zero_in       = z;
    carry_in      = c;
    negative_in   = n;
    bus.exec_done = 1;
    tick();
    bus.exec_done = 0;
    clear_ins();
  endtask

  task automatic do_jr(input logic [31:0] t);
    exec_instr(0, 0, 1, 0, 2'b00, 2'b00, 32'h0, 26'h0, t,
               0, 0, 0, 0);
  endtask

  task automatic do_alu(input logic fwe, z, c, n);
    exec_instr(0, 0, 0, 0, 2'b00, 2'b00, 32'h0, 26'h0,
               32'h0, fwe, z, c, n);
  endtask

  task automatic do_cond(input logic [1:0] cc,
                         input logic [31:0] imm);
    exec_instr(1, 0, 0, 0, cc, 2'b00, imm, 26'h0, 32'h0,
               0, 0, 0, 0);
  endtask

  task automatic do_unc(input logic [1:0] uc,
                        input logic [25:0] pa);
    exec_instr(0, 1, 0, 0, 2'b00, uc, 32'h0, pa, 32'h0,
               0, 0, 0, 0);
  endtask

  task automatic reset_and_start();
    rst = 0;
    tick();
    tick();
    rst = 1;
    tick();
    start = 1;
    tick();
    start = 0;
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    tick();
    tick();
    vectors += 10;
    if (pc !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_pc: got %h want 0", pc);
    end
    if (bus.fetch_req !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_req: got %b want 0", bus.fetch_req);
    end
    if (bus.dec_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_dv: got %b want 0", bus.dec_valid);
    end
    if (halted !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_halted: got %b want 0", halted);
    end
    if (fault !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_fault: got %b want 0", fault);
    end
    if (taken !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_taken: got %b want 0", taken);
    end
    if (link_we !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_link_we: got %b want 0", link_we);
    end
    if (link_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_link: got %h want 0", link_addr);
    end
    if (taken_count !== 16'h0) begin
      miscompares++;
      $display("FAIL rst_cnt: got %h want 0", taken_count);
    end
    if (bus.fetch_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_addr: got %h want 0", bus.fetch_addr);
    end
    rst = 1;
    tick();
    tick();
    vectors++;
    if (bus.fetch_req !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_hold: req=%b want 0", bus.fetch_req);
    end
    start = 1;
    tick();
    start = 0;
    vectors += 2;
    if (bus.fetch_req !== 1'b1) begin
      miscompares++;
      $display("FAIL start_req: got %b want 1", bus.fetch_req);
    end
    if (bus.fetch_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL start_addr: got %h want 0", bus.fetch_addr);
    end
  endtask

  task automatic test_dec_valid();
    bus.fetch_ack = 1;
    tick();
    vectors++;
    if (bus.dec_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL dv_first: got %b want 1", bus.dec_valid);
    end
    tick();
    bus.fetch_ack = 0;
    vectors += 2;
    if (bus.dec_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL dv_second: got %b want 0", bus.dec_valid);
    end
    if (bus.fetch_req !== 1'b0) begin
      miscompares++;
      $display("FAIL dv_req: got %b want 0", bus.fetch_req);
    end
    bus.exec_done = 1;
    tick();
    bus.exec_done = 0;
    vectors += 2;
    if (pc !== 32'h4) begin
      miscompares++;
      $display("FAIL dv_pc: got %h want 4", pc);
    end
    if (bus.fetch_req !== 1'b1) begin
      miscompares++;
      $display("FAIL dv_refetch: got %b want 1", bus.fetch_req);
    end
  endtask

  task automatic test_cond_not_taken();
    do_jr(32'hD000_0000);
    exp_cnt++;
    vectors += 2;
    if (pc !== 32'hD000_0000) begin
      miscompares++;
      $display("FAIL jr_pc: got %h want d0000000", pc);
    end
    if (taken !== 1'b1) begin
      miscompares++;
      $display("FAIL jr_taken: got %b want 1", taken);
    end
    do_cond(2'b01, 32'h0000_0100);
    vectors += 2;
    if (pc !== 32'hD000_0004) begin
      miscompares++;
      $display("FAIL beqz_nt_pc: got %h want d0000004", pc);
    end
    if (taken !== 1'b0) begin
      miscompares++;
      $display("FAIL beqz_nt_taken: got %b want 0", taken);
    end
  endtask

  task automatic test_cond_taken();
    do_jr(32'hCFFF_FFFC);
    exp_cnt++;
    do_alu(1, 1, 0, 0);
    vectors++;
    if (pc !== 32'hD000_0000) begin
      miscompares++;
      $display("FAIL alu_pc: got %h want d0000000", pc);
    end
    do_cond(2'b01, 32'h0000_0100);
    exp_cnt++;
    vectors += 2;
    if (pc !== 32'hD000_0104) begin
      miscompares++;
      $display("FAIL beqz_t_pc: got %h want d0000104", pc);
    end
    if (taken !== 1'b1) begin
      miscompares++;
      $display("FAIL beqz_t_taken: got %b want 1", taken);
    end
    tick();
    vectors++;
    if (taken !== 1'b0) begin
      miscompares++;
      $display("FAIL taken_pulse: got %b want 0", taken);
    end
    // bnz with z=1 held; flags_we clears z only after evaluation
    exec_instr(1, 0, 0, 0, 2'b10, 2'b00, 32'h100, 26'h0,
               32'h0, 1, 0, 0, 0);
    vectors++;
    if (pc !== 32'hD000_0108) begin
      miscompares++;
      $display("FAIL bnz_pre_pc: got %h want d0000108", pc);
    end
    do_cond(2'b01, 32'h0000_0100);
    vectors++;
    if (pc !== 32'hD000_010C) begin
      miscompares++;
      $display("FAIL beqz_upd_pc: got %h want d000010c", pc);
    end
    do_alu(1, 0, 1, 0);
    do_cond(2'b11, 32'hFFFF_FFF0);
    exp_cnt++;
    vectors++;
    if (pc !== 32'hD000_0104) begin
      miscompares++;
      $display("FAIL bcy_pc: got %h want d0000104", pc);
    end
    do_alu(1, 0, 0, 1);
    do_cond(2'b00, 32'h0000_0008);
    exp_cnt++;
    vectors++;
    if (pc !== 32'hD000_0114) begin
      miscompares++;
      $display("FAIL bneg_pc: got %h want d0000114", pc);
    end
  endtask

  task automatic test_bl();
    do_jr(32'h3000_0010);
    exp_cnt++;
    do_unc(2'b01, 26'h000_0040);
    exp_cnt++;
    vectors += 4;
    if (pc !== 32'h3000_0100) begin
      miscompares++;
      $display("FAIL bl_pc: got %h want 30000100", pc);
    end
    if (link_we !== 1'b1) begin
      miscompares++;
      $display("FAIL bl_link_we: got %b want 1", link_we);
    end
    if (link_addr !== 32'h3000_0014) begin
      miscompares++;
      $display("FAIL bl_link: got %h want 30000014", link_addr);
    end
    if (taken !== 1'b1) begin
      miscompares++;
      $display("FAIL bl_taken: got %b want 1", taken);
    end
    tick();
    vectors += 2;
    if (link_we !== 1'b0) begin
      miscompares++;
      $display("FAIL bl_pulse: got %b want 0", link_we);
    end
    if (link_addr !== 32'h3000_0014) begin
      miscompares++;
      $display("FAIL bl_hold: got %h want 30000014", link_addr);
    end
    do_unc(2'b00, 26'h3FF_FFFF);
    exp_cnt++;
    vectors += 2;
    if (pc !== 32'h3FFF_FFFC) begin
      miscompares++;
      $display("FAIL b_pc: got %h want 3ffffffc", pc);
    end
    if (link_we !== 1'b0) begin
      miscompares++;
      $display("FAIL b_link_we: got %b want 0", link_we);
    end
    do_unc(2'b10, 26'h000_0040);
    vectors += 2;
    if (pc !== 32'h4000_0000) begin
      miscompares++;
      $display("FAIL rsvd_pc: got %h want 40000000", pc);
    end
    if (taken !== 1'b0) begin
      miscompares++;
      $display("FAIL rsvd_taken: got %b want 0", taken);
    end
  endtask

  task automatic test_priority();
    exec_instr(0, 1, 1, 0, 2'b00, 2'b01, 32'h0, 26'h40,
               32'h0000_1237, 0, 0, 0, 0);
    exp_cnt++;
    vectors += 2;
    if (pc !== 32'h0000_1234) begin
      miscompares++;
      $display("FAIL prio_pc: got %h want 00001234", pc);
    end
    if (link_we !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_link_we: got %b want 0", link_we);
    end
  endtask

  task automatic test_wrap();
    do_jr(32'hFFFF_FFFC);
    exp_cnt++;
    do_alu(0, 0, 0, 0);
    vectors++;
    if (pc !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_pc: got %h want 0", pc);
    end
  endtask

  task automatic test_stats();
    logic [15:0] want;
`ifdef BRANCH_STATS_EN
    want = 16'(exp_cnt);
`else
    want = 16'h0;
`endif
    vectors++;
    if (taken_count !== want) begin
      miscompares++;
      $display("FAIL stats: got %0d want %0d",
               taken_count, want);
    end
  endtask

  task automatic test_halt_instr();
    exec_instr(0, 0, 1, 1, 2'b00, 2'b00, 32'h0, 26'h0,
               32'h0000_5000, 0, 0, 0, 0);
    vectors += 4;
    if (pc !== 32'h0) begin
      miscompares++;
      $display("FAIL halt_pc: got %h want 0", pc);
    end
    if (halted !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_halted: got %b want 1", halted);
    end
    if (fault !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_fault: got %b want 0", fault);
    end
    if (taken !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_taken: got %b want 0", taken);
    end
    start = 1;
    tick();
    start = 0;
    vectors++;
    if (bus.fetch_req !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_abs: req=%b want 0", bus.fetch_req);
    end
  endtask

  task automatic test_timeout();
    reset_and_start();
    repeat (15) tick();
    vectors++;
    if (halted !== 1'b0) begin
      miscompares++;
      $display("FAIL to_early: halted=%b want 0", halted);
    end
    bus.fetch_ack = 1;
    tick();
    bus.fetch_ack = 0;
    vectors++;
    if (bus.dec_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL to_last_ack: dv=%b want 1", bus.dec_valid);
    end
    bus.exec_done = 1;
    tick();
    bus.exec_done = 0;
    repeat (15) tick();
    vectors++;
    if (halted !== 1'b0) begin
      miscompares++;
      $display("FAIL to_edge: halted=%b want 0", halted);
    end
    tick();
    vectors += 3;
    if (halted !== 1'b1) begin
      miscompares++;
      $display("FAIL to_halted: got %b want 1", halted);
    end
    if (fault !== 1'b1) begin
      miscompares++;
      $display("FAIL to_fault: got %b want 1", fault);
    end
    if (bus.fetch_req !== 1'b0) begin
      miscompares++;
      $display("FAIL to_req: got %b want 0", bus.fetch_req);
    end
    start = 1;
    bus.fetch_ack = 1;
    tick();
    tick();
    start = 0;
    bus.fetch_ack = 0;
    vectors += 3;
    if (halted !== 1'b1 || bus.fetch_req !== 1'b0) begin
      miscompares++;
      $display("FAIL to_sticky: halted=%b req=%b want 1/0",
               halted, bus.fetch_req);
    end
    if (fault !== 1'b1) begin
      miscompares++;
      $display("FAIL to_fault_hold: got %b want 1", fault);
    end
    if (pc !== 32'h4) begin
      miscompares++;
      $display("FAIL to_pc: got %h want 4", pc);
    end
  endtask

  task automatic test_async_reset();
    reset_and_start();
    do_jr(32'h0000_8000);
    wait_fetch();
    bus.fetch_ack = 1;
    tick();
    bus.fetch_ack = 0;
    reg_br        = 1;
    register      = 32'h0000_9000;
    bus.exec_done = 1;
    #2;
    rst = 0;
    #1;
    vectors += 5;
    if (pc !== 32'h0) begin
      miscompares++;
      $display("FAIL arst_pc: got %h want 0", pc);
    end
    if (taken_count !== 16'h0) begin
      miscompares++;
      $display("FAIL arst_cnt: got %h want 0", taken_count);
    end
    if (taken !== 1'b0) begin
      miscompares++;
      $display("FAIL arst_taken: got %b want 0", taken);
    end
    if (bus.dec_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL arst_dv: got %b want 0", bus.dec_valid);
    end
    if (halted !== 1'b0) begin
      miscompares++;
      $display("FAIL arst_halted: got %b want 0", halted);
    end
    bus.exec_done = 0;
    clear_ins();
    tick();
    rst = 1;
    tick();
    vectors++;
    if (pc !== 32'h0) begin
      miscompares++;
      $display("FAIL arst_after: pc=%h want 0", pc);
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    exp_cnt       = 0;
    rst           = 0;
    start         = 0;
    bus.fetch_ack = 0;
    bus.exec_done = 0;
    clear_ins();
    test_reset();
    test_dec_valid();
    test_cond_not_taken();
    test_cond_taken();
    test_bl();
    test_priority();
    test_wrap();
    test_stats();
    test_halt_instr();
    test_timeout();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
